mul_iter: RTL

Parametrised iterative multiplier for the CPU execute stage, serving MULT and MULTU. It generalises the single-cycle signed/unsigned multiplier to a configurable operand width and a configurable number of multiplier bits retired per cycle, which trades latency against area. A start/done/ack handshake lets the pipeline stall on it, and a flush input lets the pipeline abandon an operation on an exception.

---
 rtl/mul_iter_if.sv | 21 ++
 rtl/mul_iter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mul_iter_if.sv
// Start/done/ack handshake plus operand and result bundle between the execute stage and mul_iter.
interface mul_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_sign;
    logic             flush;
    logic             ack;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, a, b, is_sign, flush, ack,
                    input  ready, busy, done, hi, lo);
    modport slave  (input  start, a, b, is_sign, flush, ack,
                    output ready, busy, done, hi, lo);
endinterface

// File: rtl/mul_iter.sv
// Iterative signed/unsigned multiplier retiring STEP multiplier bits per cycle.
// Sign is stripped at capture, magnitudes are multiplied, and the sign is reapplied on the last iteration.
module mul_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic      clk,
    input  logic      resetn,
    mul_iter_if.slave bus
);
    localparam int unsigned N     = (STEP == 0) ? 1 : WIDTH / STEP;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned SH_W  = $clog2(PW) + 1;

    if (STEP == 0 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_step
        $error("mul_iter: STEP must divide WIDTH exactly");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_load;
    logic             w_iter;
    logic             w_last;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_pp;
    logic [SH_W-1:0]  w_shamt;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_prod;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // flush overrides everything; in DONE a new start is only taken together with ack
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_iter       = 1'b0;
        w_last       = 1'b0;
        if (bus.flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_load       = 1'b1;
                        w_state_next = S_BUSY;
                    end
                end
                S_BUSY: begin
                    w_iter = 1'b1;
                    if (r_cnt == CNT_W'(N - 1)) begin
                        w_last       = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.ack) begin
                        w_state_next = S_IDLE;
                        if (bus.start) begin
                            w_load       = 1'b1;
                            w_state_next = S_BUSY;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // most-negative operand maps to 2^(WIDTH-1), which is the correct unsigned magnitude
    always_comb begin
        w_a_mag    = (bus.is_sign && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
        w_b_mag    = (bus.is_sign && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
        w_pp       = PW'(r_mcand) * PW'(r_mplier[STEP-1:0]);
        w_shamt    = SH_W'(r_cnt) * SH_W'(STEP);
        w_acc_next = r_acc + (w_pp << w_shamt);
        w_prod     = r_neg ? (~w_acc_next + PW'(1)) : w_acc_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if (w_load) begin
                r_mcand  <= w_a_mag;
                r_mplier <= w_b_mag;
                r_neg    <= bus.is_sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_cnt    <= '0;
                r_acc    <= '0;
            end else if (w_iter) begin
                r_acc    <= w_acc_next;
                r_mplier <= r_mplier >> STEP;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_hi <= w_prod[PW-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end
        end
    end

    // status flags track the state register one-for-one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_state_next != S_BUSY);
            r_busy  <= (w_state_next == S_BUSY);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule
